mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one shared single-port asynchronous SRAM between the CPU core's instruction-fetch port (I) and its load/store port (D).
- Sequences a fixed-length SRAM access for each grant.
- Returns read data to the requester and derives the per-port stall signals that the pipeline consumes. The D-port stall feeds the core's mem_stall input.
- Sits between cpu_core and the board SRAM pins.

Parameters:
- ADDR_WIDTH, 32, byte address width of both CPU ports.
- DATA_WIDTH, 32, data word width.
- SRAM_AW, 20, SRAM word-address width.
- ACCESS_CYCLES, 3, SRAM cycles per access. Must be >= 3.

Ports:
- clk_50M  in  1  system clock; all state updates on rising edge.
- reset_btn  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  ADDR_WIDTH  fetch byte address; stable while i_req=1.
- i_rdata  out  DATA_WIDTH  fetched word.
- i_ack  out  1  one-cycle completion pulse for the I port.
- i_stall  out  1  i_req & ~i_ack.
- d_req  in  1  load/store request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  active-high byte enables for a store.
- d_addr  in  ADDR_WIDTH  load/store byte address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data.
- d_ack  out  1  one-cycle completion pulse for the D port.
- d_stall  out  1  d_req & ~d_ack; drives the core's mem_stall.
- sram_addr  out  SRAM_AW  word address = granted addr[SRAM_AW+1:2].
- sram_wdata  out  DATA_WIDTH  write data.
- sram_data_oe  out  1  data-bus drive enable, for the top-level tristate.
- sram_rdata  in  DATA_WIDTH  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low SRAM strobes.
- sram_be_n  out  4  active-low byte enables.

Behaviour:
- Reset (asynchronous, any state, including mid-access):
  - State = IDLE, counter = 0, last_grant = I.
  - sram_ce_n = sram_oe_n = sram_we_n = 1, sram_be_n = 4'hF, sram_data_oe = 0.
  - sram_addr = 0, sram_wdata = 0.
  - i_ack = d_ack = 0, i_rdata = d_rdata = 0.
  - An interrupted access is abandoned; no ack is ever issued for it.
- States: IDLE, ACCESS, ACK. All SRAM outputs, ack outputs and rdata outputs are registered.
- IDLE:
  - If d_req=1 and (i_req=0 or last_grant=I), grant D.
  - Else if i_req=1, grant I.
  - On a grant: latch address, we, be and wdata; set last_grant; counter = 1; go to ACCESS.
  - With no request, stay in IDLE with the strobes inactive.
- Fairness rule:
  - D has priority on simultaneous requests.
  - Immediately after a D grant, a pending I request wins the next arbitration.
  - Continuous requests on both ports therefore alternate D, I, D, I.
- ACCESS, cycles k = 1..ACCESS_CYCLES:
  - sram_ce_n = 0 and sram_addr is valid for every k.
  - Read: sram_oe_n = 0, sram_be_n = 0, sram_data_oe = 0.
  - Write: sram_data_oe = 1, sram_wdata = latched wdata, sram_be_n = ~be.
  - Write strobe: sram_we_n = 0 only for k = 2..ACCESS_CYCLES-1 (one cycle of address/data setup and one of hold); sram_oe_n = 1.
  - At the end of k = ACCESS_CYCLES: a read samples sram_rdata into the granted port's rdata register; state goes to ACK.
- ACK (one cycle):
  - Strobes inactive; the granted port's ack = 1.
  - That port's rdata is valid and is held until its next ack. For a write, the rdata register keeps its old value.
  - No arbitration happens in ACK. The next state is IDLE, so the requester's req deassertion or change at the ack edge is never mis-sampled.
- Timing:
  - With req first high in cycle 0 while IDLE, ack is high in cycle ACCESS_CYCLES+1 (cycle 4 for the default).
  - Minimum spacing between successive grants is ACCESS_CYCLES+2 cycles.
- Stall outputs are combinational from req and the registered ack. Stall is 0 when req=0.
- Requests that arrive while the FSM is busy wait; they are neither dropped nor double-served.
- Input changes on a port while its request is pending are illegal; the latched copy is used.

Test Plan:
- Single fetch: i_req=1, i_addr=0x0000_0010, SRAM word 4 = 0x3401_0002 -> sram_addr=4 and ce_n/oe_n low in cycles 1-3; i_ack and i_rdata=0x3401_0002 in cycle 4; i_stall=1 in cycles 0-3, 0 in cycle 4.
- Byte store: d_req=1, d_we=1, d_be=4'b0010, d_addr=0x0000_0104, d_wdata=0x0000_AB00 -> sram_addr=0x41, sram_be_n=4'b1101, sram_data_oe=1 in cycles 1-3, sram_we_n=0 only in cycle 2; d_ack in cycle 4; d_rdata unchanged.
- Simultaneous requests from IDLE (fresh reset) -> D served first (d_ack cycle 4), then I granted in cycle 5 with i_ack in cycle 9.
- Both requests held high for 4 transactions -> grant order D, I, D, I; no port waits more than 2*(ACCESS_CYCLES+2) cycles.
- reset_btn pulsed low during k=2 of a store -> all strobes go inactive immediately (asynchronously); no d_ack; after release, a held d_req restarts a full 3-cycle access.
- Back-to-back loads to addresses 0x0 and 0x4 -> second grant in cycle 5, acks in cycles 4 and 9, d_rdata holds the first value through cycles 4-8.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter for one shared asynchronous SRAM.
// Each grant runs a fixed ACCESS_CYCLES strobe sequence, then pulses a one-cycle ack.
module mem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SRAM_AW       = 20,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic                  clk_50M,
    input  logic                  reset_btn,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ack,
    output logic                  i_stall,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ack,
    output logic                  d_stall,

    output logic [SRAM_AW-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  sram_data_oe,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n
);

    localparam int CW = $clog2(ACCESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    port_t                 last_grant_q, last_grant_d;
    port_t                 grant_q, grant_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;

    logic [SRAM_AW-1:0]    sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
    logic                  sram_ce_n_q, sram_ce_n_d;
    logic                  sram_oe_n_q, sram_oe_n_d;
    logic                  sram_we_n_q, sram_we_n_d;
    logic [3:0]            sram_be_n_q, sram_be_n_d;
    logic                  sram_data_oe_q, sram_data_oe_d;

    logic                  i_ack_q, i_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    // Only the word-address bits of the byte addresses reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[ADDR_WIDTH-1:SRAM_AW+2], i_addr[1:0],
                                d_addr[ADDR_WIDTH-1:SRAM_AW+2], d_addr[1:0]};

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        we_d           = we_q;
        be_d           = be_q;
        sram_addr_d    = sram_addr_q;
        sram_wdata_d   = sram_wdata_q;
        sram_ce_n_d    = 1'b1;
        sram_oe_n_d    = 1'b1;
        sram_we_n_d    = 1'b1;
        sram_be_n_d    = 4'hF;
        sram_data_oe_d = 1'b0;
        i_ack_d        = 1'b0;
        d_ack_d        = 1'b0;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                // D wins ties unless it was the last port served and I is waiting.
                if (d_req && (!i_req || last_grant_q == PORT_I)) begin
                    grant_d      = PORT_D;
                    last_grant_d = PORT_D;
                    we_d         = d_we;
                    be_d         = d_be;
                    sram_addr_d  = d_addr[SRAM_AW+1:2];
                    sram_wdata_d = d_wdata;
                    cnt_d        = CNT_ONE;
                    state_d      = ST_ACCESS;
                end else if (i_req) begin
                    grant_d      = PORT_I;
                    last_grant_d = PORT_I;
                    we_d         = 1'b0;
                    be_d         = 4'hF;
                    sram_addr_d  = i_addr[SRAM_AW+1:2];
                    cnt_d        = CNT_ONE;
                    state_d      = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ACK;
                    if (grant_q == PORT_D) begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = sram_rdata;
                        end
                    end else begin
                        i_ack_d = 1'b1;
                        if (!we_q) begin
                            i_rdata_d = sram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Strobes are registered, so they are derived from the cycle about to begin.
        if (state_d == ST_ACCESS) begin
            sram_ce_n_d = 1'b0;
            if (we_d) begin
                sram_data_oe_d = 1'b1;
                sram_be_n_d    = ~be_d;
                sram_we_n_d    = !((cnt_d >= CNT_TWO) && (cnt_d < CNT_LAST));
            end else begin
                sram_oe_n_d = 1'b0;
                sram_be_n_d = 4'h0;
            end
        end
    end

    always_ff @(posedge clk_50M or negedge reset_btn) begin
        if (!reset_btn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            last_grant_q   <= PORT_I;
            grant_q        <= PORT_I;
            we_q           <= 1'b0;
            be_q           <= 4'h0;
            sram_addr_q    <= '0;
            sram_wdata_q   <= '0;
            sram_ce_n_q    <= 1'b1;
            sram_oe_n_q    <= 1'b1;
            sram_we_n_q    <= 1'b1;
            sram_be_n_q    <= 4'hF;
            sram_data_oe_q <= 1'b0;
            i_ack_q        <= 1'b0;
            d_ack_q        <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            grant_q        <= grant_d;
            we_q           <= we_d;
            be_q           <= be_d;
            sram_addr_q    <= sram_addr_d;
            sram_wdata_q   <= sram_wdata_d;
            sram_ce_n_q    <= sram_ce_n_d;
            sram_oe_n_q    <= sram_oe_n_d;
            sram_we_n_q    <= sram_we_n_d;
            sram_be_n_q    <= sram_be_n_d;
            sram_data_oe_q <= sram_data_oe_d;
            i_ack_q        <= i_ack_d;
            d_ack_q        <= d_ack_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
        end
    end

    assign sram_addr    = sram_addr_q;
    assign sram_wdata   = sram_wdata_q;
    assign sram_ce_n    = sram_ce_n_q;
    assign sram_oe_n    = sram_oe_n_q;
    assign sram_we_n    = sram_we_n_q;
    assign sram_be_n    = sram_be_n_q;
    assign sram_data_oe = sram_data_oe_q;

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    assign i_stall = i_req & ~i_ack_q;
    assign d_stall = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-exact strobe, ack, stall and arbitration checks
// against hand-computed values, using a read-only behavioural SRAM image.
module tb_mem_arbiter;

    logic        clk_50M = 1'b0;
    logic        reset_btn = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack, i_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'h0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack, d_stall;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_data_oe;
    logic [31:0] sram_rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]  sram_be_n;

    logic [31:0] mem [0:255];
    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter dut (
        .clk_50M      (clk_50M),
        .reset_btn    (reset_btn),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_ack        (i_ack),
        .i_stall      (i_stall),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_be         (d_be),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ack        (d_ack),
        .d_stall      (d_stall),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_data_oe (sram_data_oe),
        .sram_rdata   (sram_rdata),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_be_n    (sram_be_n)
    );

    always #5 clk_50M = ~clk_50M;

    assign sram_rdata = mem[sram_addr[7:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge; samples are taken 3 ns later.
    task automatic tick;
        @(posedge clk_50M);
        #1;
    endtask

    task automatic do_reset;
        reset_btn = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(posedge clk_50M);
        #3 reset_btn = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]    = 32'hCAFE_0001;
        mem[1]    = 32'hBEEF_0002;
        mem[2]    = 32'hDEAD_BEEF;
        mem[4]    = 32'h3401_0002;
        mem[8'h41] = 32'h1122_3344;

        // Reset state
        do_reset();
        check_eq("rst_ce_n", 32'(sram_ce_n), 32'h1);
        check_eq("rst_oe_n", 32'(sram_oe_n), 32'h1);
        check_eq("rst_we_n", 32'(sram_we_n), 32'h1);
        check_eq("rst_be_n", 32'(sram_be_n), 32'hF);
        check_eq("rst_data_oe", 32'(sram_data_oe), 32'h0);
        check_eq("rst_addr", 32'(sram_addr), 32'h0);
        check_eq("rst_wdata", sram_wdata, 32'h0);
        check_eq("rst_acks", 32'({i_ack, d_ack}), 32'h0);
        check_eq("rst_i_rdata", i_rdata, 32'h0);
        check_eq("rst_d_rdata", d_rdata, 32'h0);

        // Single fetch from word 4
        tick();
        i_req = 1'b1; i_addr = 32'h0000_0010;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) tick();
            #3;
            if (c >= 1 && c <= 3) begin
                check_eq($sformatf("f_addr_c%0d", c), 32'(sram_addr), 32'h4);
                check_eq($sformatf("f_ce_oe_we_c%0d", c), 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h1);
                check_eq($sformatf("f_data_oe_c%0d", c), 32'(sram_data_oe), 32'h0);
            end
            if (c <= 3) begin
                check_eq($sformatf("f_stall_c%0d", c), 32'(i_stall), 32'h1);
                check_eq($sformatf("f_ack_c%0d", c), 32'(i_ack), 32'h0);
            end
        end
        check_eq("f_ack_c4", 32'(i_ack), 32'h1);
        check_eq("f_rdata_c4", i_rdata, 32'h3401_0002);
        check_eq("f_stall_c4", 32'(i_stall), 32'h0);
        check_eq("f_strobes_c4", 32'({sram_ce_n, sram_oe_n}), 32'h3);
        $display("txn I fetch addr=0x00000010 rdata=0x%08h", i_rdata);
        tick();
        i_req = 1'b0;
        #3 check_eq("f_stall_idle", 32'(i_stall), 32'h0);

        // Byte store to word 0x41, lane 1
        tick();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010;
        d_addr = 32'h0000_0104; d_wdata = 32'h0000_AB00;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) tick();
            #3;
            if (c >= 1 && c <= 3) begin
                check_eq($sformatf("s_addr_c%0d", c), 32'(sram_addr), 32'h41);
                check_eq($sformatf("s_be_n_c%0d", c), 32'(sram_be_n), 32'hD);
                check_eq($sformatf("s_data_oe_c%0d", c), 32'(sram_data_oe), 32'h1);
                check_eq($sformatf("s_wdata_c%0d", c), sram_wdata, 32'h0000_AB00);
                check_eq($sformatf("s_ce_oe_c%0d", c), 32'({sram_ce_n, sram_oe_n}), 32'h1);
                check_eq($sformatf("s_we_n_c%0d", c), 32'(sram_we_n), (c == 2) ? 32'h0 : 32'h1);
            end
            if (c <= 3) check_eq($sformatf("s_ack_c%0d", c), 32'(d_ack), 32'h0);
        end
        check_eq("s_ack_c4", 32'(d_ack), 32'h1);
        check_eq("s_rdata_kept", d_rdata, 32'h0);
        check_eq("s_data_oe_c4", 32'(sram_data_oe), 32'h0);
        check_eq("s_stall_c4", 32'(d_stall), 32'h0);
        $display("txn D store addr=0x00000104 be=0010 wdata=0x0000ab00");
        tick();
        d_req = 1'b0; d_we = 1'b0;

        // Simultaneous requests after a fresh reset: D first, then I
        do_reset();
        tick();
        i_req = 1'b1; i_addr = 32'h0000_0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            if (c == 5) d_req = 1'b0;
            #3;
            if (c == 1) check_eq("sim_first_addr", 32'(sram_addr), 32'h2);
            if (c == 4) begin
                check_eq("sim_d_ack", 32'(d_ack), 32'h1);
                check_eq("sim_d_rdata", d_rdata, 32'hDEAD_BEEF);
                check_eq("sim_i_wait", 32'({i_ack, i_stall, d_stall}), 32'h2);
                $display("txn D load addr=0x00000008 rdata=0x%08h", d_rdata);
            end
            if (c == 5) check_eq("sim_c5_ce_n", 32'(sram_ce_n), 32'h1);
            if (c == 6) check_eq("sim_second_addr", 32'(sram_addr), 32'h4);
            if (c >= 5 && c <= 8) check_eq($sformatf("sim_acks_c%0d", c), 32'({i_ack, d_ack}), 32'h0);
        end
        check_eq("sim_i_ack_c9", 32'(i_ack), 32'h1);
        check_eq("sim_i_rdata", i_rdata, 32'h3401_0002);
        $display("txn I fetch addr=0x00000010 rdata=0x%08h", i_rdata);
        tick();
        i_req = 1'b0;

        // Both ports held: grants alternate D, I, D, I
        begin
            int    nack = 0;
            int    ack_cyc [4];
            logic  ack_port [4];
            do_reset();
            tick();
            i_req = 1'b1; i_addr = 32'h0000_0010;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008;
            for (int c = 0; c <= 24; c++) begin
                if (c > 0) tick();
                #3;
                if (d_ack && nack < 4) begin
                    ack_cyc[nack] = c; ack_port[nack] = 1'b1; nack++;
                    $display("txn D load ack cycle=%0d rdata=0x%08h", c, d_rdata);
                end
                if (i_ack && nack < 4) begin
                    ack_cyc[nack] = c; ack_port[nack] = 1'b0; nack++;
                    $display("txn I fetch ack cycle=%0d rdata=0x%08h", c, i_rdata);
                end
            end
            tick();
            i_req = 1'b0; d_req = 1'b0;
            check_eq("alt_count", 32'(nack), 32'd4);
            if (nack == 4) begin
                check_eq("alt_order", 32'({ack_port[0], ack_port[1], ack_port[2], ack_port[3]}), 32'hA);
                check_eq("alt_cyc0", 32'(ack_cyc[0]), 32'd4);
                check_eq("alt_cyc1", 32'(ack_cyc[1]), 32'd9);
                check_eq("alt_cyc2", 32'(ack_cyc[2]), 32'd14);
                check_eq("alt_cyc3", 32'(ack_cyc[3]), 32'd19);
                check_eq("alt_d_wait_ok", 32'((ack_cyc[2] - ack_cyc[0]) <= 10), 32'h1);
                check_eq("alt_i_wait_ok", 32'((ack_cyc[3] - ack_cyc[1]) <= 10), 32'h1);
            end
        end

        // Reset pulse in the middle of a store's write strobe
        do_reset();
        tick();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
        d_addr = 32'h0000_0104; d_wdata = 32'h55AA_55AA;
        #3;
        tick(); #3;
        check_eq("rs_c1_we_n", 32'(sram_we_n), 32'h1);
        tick(); #3;
        check_eq("rs_c2_we_n", 32'(sram_we_n), 32'h0);
        reset_btn = 1'b0;
        #1;
        check_eq("rs_async_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
        check_eq("rs_async_be_n", 32'(sram_be_n), 32'hF);
        check_eq("rs_async_data_oe", 32'(sram_data_oe), 32'h0);
        tick();
        check_eq("rs_held_ack", 32'(d_ack), 32'h0);
        #2 reset_btn = 1'b1;
        #1;
        check_eq("rs_rel_ce_n", 32'(sram_ce_n), 32'h1);
        check_eq("rs_rel_stall", 32'(d_stall), 32'h1);
        for (int c = 1; c <= 4; c++) begin
            tick(); #3;
            if (c <= 3) begin
                check_eq($sformatf("rs_ce_n_c%0d", c), 32'(sram_ce_n), 32'h0);
                check_eq($sformatf("rs_we_n_c%0d", c), 32'(sram_we_n), (c == 2) ? 32'h0 : 32'h1);
                check_eq($sformatf("rs_ack_c%0d", c), 32'(d_ack), 32'h0);
            end
        end
        check_eq("rs_ack_c4", 32'(d_ack), 32'h1);
        $display("txn D store (restarted) addr=0x00000104 be=1111 wdata=0x55aa55aa");
        tick();
        d_req = 1'b0; d_we = 1'b0;

        // Back-to-back loads from 0x0 and 0x4
        do_reset();
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0000;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            if (c == 5) d_addr = 32'h0000_0004;
            #3;
            if (c >= 4 && c <= 8) check_eq($sformatf("bb_hold_c%0d", c), d_rdata, 32'hCAFE_0001);
            if (c == 4) begin
                check_eq("bb_ack1", 32'(d_ack), 32'h1);
                $display("txn D load addr=0x00000000 rdata=0x%08h", d_rdata);
            end
            if (c >= 5 && c <= 8) check_eq($sformatf("bb_ack_c%0d", c), 32'(d_ack), 32'h0);
            if (c == 6) check_eq("bb_addr2", 32'(sram_addr), 32'h1);
        end
        check_eq("bb_ack2", 32'(d_ack), 32'h1);
        check_eq("bb_rdata2", d_rdata, 32'hBEEF_0002);
        $display("txn D load addr=0x00000004 rdata=0x%08h", d_rdata);
        tick();
        d_req = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
